// File: rtl/pcileech_sysctl_rstled_if.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_sysctl_rstled_if
// Description : LED channel bundle between a board top and the PCILeech system
//               controller.
//                 led_mode       2*NUM_LEDS  per-LED mode, [2i+1:2i]
//                                            (00 off, 01 on, 10 blink,
//                                            11 activity)
//                 led_act        NUM_LEDS    activity pulse per LED
//                 led_pwron_inv  NUM_LEDS    XOR this LED with the power-on
//                                            blink
//                 led            NUM_LEDS    registered LED drive, active-high
//               master = board top / user logic, slave = system controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pcileech_sysctl_rstled_if #(
  parameter int NUM_LEDS = 2
);
  logic [2*NUM_LEDS-1:0] led_mode;
  logic [NUM_LEDS-1:0]   led_act;
  logic [NUM_LEDS-1:0]   led_pwron_inv;
  logic [NUM_LEDS-1:0]   led;

  modport master (
    output led_mode,
    output led_act,
    output led_pwron_inv,
    input  led
  );

  modport slave (
    input  led_mode,
    input  led_act,
    input  led_pwron_inv,
    output led
  );
endinterface
`default_nettype wire

// File: rtl/pcileech_sysctl_rstled.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_sysctl_rstled
// Description : Board-level system controller shared by all PCILeech tops.
//               - free-running tick counter
//               - reset sequencer: async assert, two-flop synchronous
//                 deassert, timed hold, drives fabric reset and the active-low
//                 FT601/FT2232 reset pad
//               - N-channel LED driver with per-LED mode, activity pulse
//                 stretching and a one-shot power-on blink window
// Ports       : clk            system clock
//               rst            async active-high reset (PLL !locked / POR)
//               ext_rst_req_i  soft-reset request pulse (only with
//                              PCILEECH_SYSCTL_EXTRST_EN)
//               tickcount_o    free-running cycle count
//               rst_out_o      fabric reset, async assert / sync deassert
//               rst_out_n_o    inverted rst_out_o for the FT601 reset pad
//               pwron_blink_o  blink during the power-on window, else 0
//               led_if         LED bundle (slave side)
// Config      : define PCILEECH_SYSCTL_EXTRST_EN to add the ext_rst_req_i
//               soft-reset path; without it rst_out_o follows rst only.
// Revision    : 1.0 - initial release
// ============================================================================
module pcileech_sysctl_rstled #(
  parameter int TICK_W    = 64,
  parameter int RST_HOLD  = 64,
  parameter int NUM_LEDS  = 2,
  parameter int BLINK_BIT = 24,
  parameter int PWRON_BIT = 27,
  parameter int STRETCH_W = 22
) (
  input  wire                 clk,
  input  wire                 rst,
`ifdef PCILEECH_SYSCTL_EXTRST_EN
  input  wire                 ext_rst_req_i,
`endif
  output logic [TICK_W-1:0]   tickcount_o,
  output logic                rst_out_o,
  output logic                rst_out_n_o,
  output logic                pwron_blink_o,
  pcileech_sysctl_rstled_if.slave led_if
);

  localparam logic [15:0]          c_HOLD_TGT    = 16'(RST_HOLD);
  localparam logic [STRETCH_W-1:0] c_STRETCH_MAX = {STRETCH_W{1'b1}};

  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0]                   tick_q,        tick_d;
  logic                                rst_meta_q,    rst_sync_q;
  state_t                              state_q,       state_d;
  logic [15:0]                         hold_q,        hold_d;
  logic                                rst_out_q,     rst_out_d;
  logic                                pwron_done_q,  pwron_done_d;
  logic                                pwron_blink_q, pwron_blink_d;
  logic [NUM_LEDS-1:0][STRETCH_W-1:0]  stretch_q,     stretch_d;
  logic [NUM_LEDS-1:0]                 led_q,         led_d;
  logic                                w_ext_req;

`ifdef PCILEECH_SYSCTL_EXTRST_EN
  assign w_ext_req = ext_rst_req_i;
`else
  assign w_ext_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q        <= '0;
      rst_meta_q    <= 1'b1;
      rst_sync_q    <= 1'b1;
      state_q       <= ST_HOLD;
      hold_q        <= '0;
      rst_out_q     <= 1'b1;
      pwron_done_q  <= 1'b0;
      pwron_blink_q <= 1'b0;
      stretch_q     <= '0;
      led_q         <= '0;
    end else begin
      tick_q        <= tick_d;
      rst_meta_q    <= 1'b0;
      rst_sync_q    <= rst_meta_q;
      state_q       <= state_d;
      hold_q        <= hold_d;
      rst_out_q     <= rst_out_d;
      pwron_done_q  <= pwron_done_d;
      pwron_blink_q <= pwron_blink_d;
      stretch_q     <= stretch_d;
      led_q         <= led_d;
    end
  end

  // --------------------------------------------------------------------------
  // Tick counter and power-on window
  // --------------------------------------------------------------------------
  assign tick_d        = tick_q + TICK_W'(1);
  // The window closes for good on the first PWRON_BIT set; the sticky flag
  // keeps it from reopening after the tick counter wraps.
  assign pwron_done_d  = pwron_done_q | tick_q[PWRON_BIT];
  assign pwron_blink_d = tick_q[BLINK_BIT] & ~pwron_done_d;

  // --------------------------------------------------------------------------
  // Reset sequencer
  // The hold counter only starts once the reset has passed the two-flop
  // synchroniser, so the hold time is measured from a clean, synchronous
  // deassertion.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_HOLD: begin
        if (w_ext_req) begin
          hold_d = '0;
        end else if (!rst_sync_q) begin
          hold_d = hold_q + 16'd1;
          if (hold_q + 16'd1 == c_HOLD_TGT) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_ext_req) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        hold_d  = '0;
      end
    endcase
  end

  assign rst_out_d = (state_d == ST_HOLD);

  // --------------------------------------------------------------------------
  // LED channels
  // Stretch counters run in every mode so that switching back to activity
  // shows any activity that is still being stretched. LEDs are forced off
  // in the same cycle the fabric reset is high.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      logic [1:0] w_mode;
      logic       w_base;

      assign w_mode = led_if.led_mode[2*gi +: 2];

      assign stretch_d[gi] = led_if.led_act[gi]      ? c_STRETCH_MAX :
                             (stretch_q[gi] != '0)   ? stretch_q[gi] - STRETCH_W'(1) :
                                                       '0;

      always_comb begin
        w_base = 1'b0;
        case (w_mode)
          2'b00:   w_base = 1'b0;
          2'b01:   w_base = 1'b1;
          2'b10:   w_base = tick_q[BLINK_BIT];
          default: w_base = (stretch_q[gi] != '0) | led_if.led_act[gi];
        endcase
      end

      assign led_d[gi] = rst_out_d ? 1'b0
                                   : (w_base ^ (led_if.led_pwron_inv[gi] & pwron_blink_d));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tickcount_o   = tick_q;
  assign rst_out_o     = rst_out_q;
  assign rst_out_n_o   = ~rst_out_q;
  assign pwron_blink_o = pwron_blink_q;
  assign led_if.led    = led_q;

endmodule
`default_nettype wire

// File: tb/tb_pcileech_sysctl_rstled.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcileech_sysctl_rstled
// Description : Self-checking bench for pcileech_sysctl_rstled. A reference
//               model expressed in "edges since reset release" and "edges
//               since last event" predicts every output after each clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcileech_sysctl_rstled;

  localparam int NL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tick;
  logic       rst_out;
  logic       rst_out_n;
  logic       blink;
`ifdef PCILEECH_SYSCTL_EXTRST_EN
  logic       ext_req;
`endif

  always #5 clk = ~clk;

  pcileech_sysctl_rstled_if #(.NUM_LEDS(NL)) led_if ();

  pcileech_sysctl_rstled #(
    .TICK_W    (8),
    .RST_HOLD  (4),
    .NUM_LEDS  (NL),
    .BLINK_BIT (1),
    .PWRON_BIT (4),
    .STRETCH_W (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef PCILEECH_SYSCTL_EXTRST_EN
    .ext_rst_req_i (ext_req),
`endif
    .tickcount_o   (tick),
    .rst_out_o     (rst_out),
    .rst_out_n_o   (rst_out_n),
    .pwron_blink_o (blink),
    .led_if        (led_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int              e;              // clock edges since rst released
  int              last_act [NL];  // edge index of most recent activity pulse
  int              last_ext;       // edge index of most recent soft-reset request
  logic [2*NL-1:0] s_mode;         // inputs as sampled on the last edge
  logic [NL-1:0]   s_inv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tick"},  32'(tick),       0);
    chk({tag, "_rst"},   32'(rst_out),    1);
    chk({tag, "_rstn"},  32'(rst_out_n),  0);
    chk({tag, "_blink"}, 32'(blink),      0);
    chk({tag, "_led"},   32'(led_if.led), 0);
  endtask

  task automatic model_clear();
    e = 0;
    for (int i = 0; i < NL; i++) last_act[i] = -1000;
    last_ext = -1000;
  endtask

  task automatic check_all();
    int p;
    int exp_rst;
    int exp_blink;
    int base;
    int exp_led;
    logic [1:0] m;
    p = e - 1;  // tick value seen by the logic on the last edge
    // Fabric reset is high for the first 5 edges after release, and for
    // 4 edges starting with any soft-reset request edge.
    exp_rst   = ((e <= 5) || (e - last_ext <= 3)) ? 1 : 0;
    // Blink only while no tick value with bit 4 set has been seen yet.
    exp_blink = (p < 16) ? ((p >> 1) & 1) : 0;
    chk("tick",  32'(tick),      e % 256);
    chk("rst",   32'(rst_out),   exp_rst);
    chk("rstn",  32'(rst_out_n), 1 - exp_rst);
    chk("blink", 32'(blink),     exp_blink);
    for (int i = 0; i < NL; i++) begin
      m = s_mode[2*i +: 2];
      case (m)
        2'b00:   base = 0;
        2'b01:   base = 1;
        2'b10:   base = (p >> 1) & 1;
        default: base = (e - last_act[i] <= 7) ? 1 : 0;
      endcase
      exp_led = exp_rst ? 0 : (base ^ (int'(s_inv[i]) & exp_blink));
      chk($sformatf("led%0d", i), 32'(led_if.led[i]), exp_led);
    end
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    s_mode = led_if.led_mode;
    s_inv  = led_if.led_pwron_inv;
    for (int i = 0; i < NL; i++)
      if (led_if.led_act[i]) last_act[i] = e;
`ifdef PCILEECH_SYSCTL_EXTRST_EN
    if (ext_req) last_ext = e;
`endif
    #1;
    check_all();
  endtask

  task automatic rand_inputs();
    led_if.led_mode      = 4'($urandom);
    led_if.led_pwron_inv = 2'($urandom);
    for (int i = 0; i < NL; i++)
      led_if.led_act[i] = ($urandom_range(0, 5) == 0);
`ifdef PCILEECH_SYSCTL_EXTRST_EN
    ext_req = ($urandom_range(0, 40) == 0);
`endif
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_reset({tag, "_async"});
    repeat (3) @(posedge clk);
    #1;
    chk_reset({tag, "_held"});
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    rst                  = 1'b1;
    led_if.led_mode      = '0;
    led_if.led_act       = '0;
    led_if.led_pwron_inv = '0;
`ifdef PCILEECH_SYSCTL_EXTRST_EN
    ext_req              = 1'b0;
`endif
    model_clear();

    // Power-on: reset hold, LEDs gated, LED1 on with power-on inversion
    do_reset("por");
    led_if.led_mode      = 4'b0111;   // LED1 on, LED0 activity
    led_if.led_pwron_inv = 2'b10;
    repeat (8) step();

    // Activity stretch with a re-trigger four cycles later
    led_if.led_act[0] = 1'b1; step();
    led_if.led_act[0] = 1'b0; repeat (3) step();
    led_if.led_act[0] = 1'b1; step();
    led_if.led_act[0] = 1'b0; repeat (10) step();

    // LED1 mode sequence on -> blink -> off
    led_if.led_mode[3:2] = 2'b01; repeat (3) step();
    led_if.led_mode[3:2] = 2'b10; repeat (6) step();
    led_if.led_mode[3:2] = 2'b00; repeat (3) step();

    // Long random run across the tick wrap
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      step();
    end

    // Mid-run async reset while LED0 is stretching
    led_if.led_mode = 4'b0111;
    led_if.led_act  = 2'b01;
    step();
    led_if.led_act  = 2'b00;
    step();
    #2;
    do_reset("mid");
    for (int n = 0; n < 60; n++) begin
      rand_inputs();
      step();
    end

`ifdef PCILEECH_SYSCTL_EXTRST_EN
    // Directed soft reset in RUN with activity in flight
    led_if.led_mode = 4'b0111;
    led_if.led_act  = 2'b01;
    ext_req         = 1'b1;
    step();
    led_if.led_act  = 2'b00;
    ext_req         = 1'b0;
    repeat (8) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
